// File: rtl/priority_arbiter_n.sv
// priority_arbiter_n: N-way arbiter (fixed priority or round-robin) with a per-owner hold limit.
// Optional macro ARB_LOCK_EN adds a lock input that lets an owner stay past MAX_HOLD.
module priority_arbiter_n #(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pr_en,
  input  logic                 rot_en,
  input  logic [N-1:0]         req,
`ifdef ARB_LOCK_EN
  input  logic [N-1:0]         lock,
`endif
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 busy
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_n;
  logic [N-1:0]  gnt_n;
  logic [IW-1:0] gnt_id_n;
  logic          busy_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] last_owner, last_n;
  logic [IW-1:0] win_id;
  logic          win_found;
  logic          owner_req, at_max, locked, keep, expire;
  logic [N-1:0]  cand;

  // Index visited at step k of the search; round-robin starts just past the last owner
  function automatic logic [IW-1:0] scan_idx(input logic [IW-1:0] base, input logic rr,
                                             input int unsigned k);
    int unsigned s;
    s = rr ? (32'(base) + 32'd1 + k) % N : k;
    return IW'(s);
  endfunction

  assign owner_req = req[gnt_id];
  assign at_max    = (cnt == HOLD_MAX);
`ifdef ARB_LOCK_EN
  assign locked    = lock[gnt_id] & owner_req;
`else
  assign locked    = 1'b0;
`endif
  assign keep      = (state == GRANT) && owner_req && (!at_max || locked);
  assign expire    = (state == GRANT) && owner_req && at_max && !locked;
  // An owner whose hold expired sits out this one arbitration
  assign cand      = expire ? (req & ~gnt) : req;

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!win_found && cand[scan_idx(last_owner, rot_en, k)]) begin
        win_found = 1'b1;
        win_id    = scan_idx(last_owner, rot_en, k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      gnt        <= '0;
      gnt_id     <= '0;
      busy       <= 1'b0;
      cnt        <= '0;
      last_owner <= IW'(N - 1);
    end else begin
      state      <= state_n;
      gnt        <= gnt_n;
      gnt_id     <= gnt_id_n;
      busy       <= busy_n;
      cnt        <= cnt_n;
      last_owner <= last_n;
    end
  end

  always_comb begin
    state_n  = state;
    gnt_n    = gnt;
    gnt_id_n = gnt_id;
    busy_n   = busy;
    cnt_n    = cnt;
    last_n   = last_owner;
    if (pr_en) begin
      case (state)
        IDLE: begin
          if (win_found) begin
            state_n  = GRANT;
            gnt_n    = N'(1) << win_id;
            gnt_id_n = win_id;
            busy_n   = 1'b1;
            cnt_n    = CW'(1);
            last_n   = win_id;
          end
        end
        GRANT: begin
          if (keep) begin
            if (!at_max) cnt_n = cnt + CW'(1);
          end else if (win_found) begin
            gnt_n    = N'(1) << win_id;
            gnt_id_n = win_id;
            busy_n   = 1'b1;
            cnt_n    = CW'(1);
            last_n   = win_id;
          end else if (expire) begin
            // Sole requester after expiry: re-granted in place with a fresh count
            cnt_n  = CW'(1);
            last_n = gnt_id;
          end else begin
            state_n  = IDLE;
            gnt_n    = '0;
            gnt_id_n = '0;
            busy_n   = 1'b0;
            cnt_n    = '0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_priority_arbiter_n.sv
// Directed self-checking bench for priority_arbiter_n (N=4, MAX_HOLD=8).
// Build with ARB_LOCK_EN defined to also exercise the lock input.
module tb_priority_arbiter_n;

  logic       clk;
  logic       rst;
  logic       pr_en;
  logic       rot_en;
  logic [3:0] req;
`ifdef ARB_LOCK_EN
  logic [3:0] lock;
`endif
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;

  int total;
  int bad;

  priority_arbiter_n #(.N(4), .MAX_HOLD(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .pr_en  (pr_en),
    .rot_en (rot_en),
    .req    (req),
`ifdef ARB_LOCK_EN
    .lock   (lock),
`endif
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; pr_en = 1'b0; rot_en = 1'b0; req = 4'b1111;
    step();
    total++;
    if (gnt !== 4'b0000 || gnt_id !== 2'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset: gnt=%b id=%0d busy=%b, want 0000/0/0", gnt, gnt_id, busy);
    end
    rst = 1'b1;
    step();
    total++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_frozen: gnt=%b busy=%b, want 0000/0", gnt, busy);
    end
  endtask

  task automatic test_fixed();
    pr_en = 1'b1; rot_en = 1'b0; req = 4'b1010;
    for (int i = 0; i < 8; i++) begin
      step();
      total++;
      if (gnt !== 4'b0010 || gnt_id !== 2'd1 || busy !== 1'b1) begin
        bad++;
        $display("FAIL fixed_hold[%0d]: gnt=%b id=%0d busy=%b, want 0010/1/1", i, gnt, gnt_id, busy);
      end
    end
    step();
    total++;
    if (gnt !== 4'b1000 || gnt_id !== 2'd3 || busy !== 1'b1) begin
      bad++;
      $display("FAIL fixed_pass: gnt=%b id=%0d busy=%b, want 1000/3/1", gnt, gnt_id, busy);
    end
    req = 4'b0000;
    step();
    total++;
    if (gnt !== 4'b0000 || gnt_id !== 2'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL fixed_idle: gnt=%b id=%0d busy=%b, want 0000/0/0", gnt, gnt_id, busy);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [5];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst = 1'b0;
    step();
    rst = 1'b1; pr_en = 1'b1; rot_en = 1'b1; req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (gnt !== exp_g[i] || busy !== 1'b1) begin
        bad++;
        $display("FAIL rr_order[%0d]: gnt=%b busy=%b, want %b/1", i, gnt, busy, exp_g[i]);
      end
      req = 4'b1111 & ~exp_g[i];
    end
    req = 4'b0000;
    step();
    total++;
    if (busy !== 1'b0 || gnt !== 4'b0000) begin
      bad++;
      $display("FAIL rr_idle: gnt=%b busy=%b, want 0000/0", gnt, busy);
    end
  endtask

  task automatic test_solo_expiry();
    rot_en = 1'b0; req = 4'b0100;
    for (int i = 0; i < 12; i++) begin
      step();
      total++;
      if (gnt !== 4'b0100 || gnt_id !== 2'd2) begin
        bad++;
        $display("FAIL solo_hold[%0d]: gnt=%b id=%0d, want 0100/2", i, gnt, gnt_id);
      end
    end
    req = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (gnt !== 4'b0100) begin
        bad++;
        $display("FAIL solo_restart[%0d]: gnt=%b, want 0100", i, gnt);
      end
    end
    step();
    total++;
    if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
      bad++;
      $display("FAIL solo_pass: gnt=%b id=%0d, want 0001/0", gnt, gnt_id);
    end
  endtask

  task automatic test_freeze();
    logic [3:0] fz_req [5];
    fz_req = '{4'b0001, 4'b0000, 4'b1011, 4'b1111, 4'b0010};
    req = 4'b0000;
    step();
    req = 4'b0100;
    step(); step(); step();
    total++;
    if (gnt !== 4'b0100) begin
      bad++;
      $display("FAIL freeze_setup: gnt=%b, want 0100", gnt);
    end
    pr_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req = fz_req[i];
      step();
      total++;
      if (gnt !== 4'b0100 || gnt_id !== 2'd2 || busy !== 1'b1) begin
        bad++;
        $display("FAIL freeze[%0d]: gnt=%b id=%0d busy=%b, want 0100/2/1", i, gnt, gnt_id, busy);
      end
    end
    pr_en = 1'b1; req = 4'b0101;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (gnt !== 4'b0100) begin
        bad++;
        $display("FAIL freeze_resume[%0d]: gnt=%b, want 0100", i, gnt);
      end
    end
    step();
    total++;
    if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
      bad++;
      $display("FAIL freeze_pass: gnt=%b id=%0d, want 0001/0", gnt, gnt_id);
    end
  endtask

  task automatic test_reset_mid();
    rot_en = 1'b1; req = 4'b1111; rst = 1'b0;
    step();
    total++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || gnt_id !== 2'd0) begin
      bad++;
      $display("FAIL reset_mid: gnt=%b id=%0d busy=%b, want 0000/0/0", gnt, gnt_id, busy);
    end
    rst = 1'b1;
    step();
    total++;
    if (gnt !== 4'b0001 || busy !== 1'b1) begin
      bad++;
      $display("FAIL reset_rr_start: gnt=%b busy=%b, want 0001/1", gnt, busy);
    end
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    rst = 1'b0; lock = 4'b0000;
    step();
    rst = 1'b1; rot_en = 1'b0; req = 4'b0010; lock = 4'b0010;
    step();
    req = 4'b0011;
    for (int i = 0; i < 20; i++) begin
      step();
      total++;
      if (gnt !== 4'b0010) begin
        bad++;
        $display("FAIL lock_hold[%0d]: gnt=%b, want 0010", i, gnt);
      end
    end
    lock = 4'b0000;
    step();
    total++;
    if (gnt !== 4'b0001) begin
      bad++;
      $display("FAIL lock_release: gnt=%b, want 0001", gnt);
    end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
`ifdef ARB_LOCK_EN
    lock  = 4'b0000;
`endif
    test_reset();
    test_fixed();
    test_round_robin();
    test_solo_expiry();
    test_freeze();
    test_reset_mid();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
